uart_debug_echo: RTL and testbench
==================================

# uart_debug_echo

Download-echo stage that sits directly downstream of the UART program downloader. It consumes the downloader's memory-write stream (write enable plus 32-bit data) and retransmits every word over a UART TX line at the same baud rate, so the host can verify the image byte by byte. It also keeps a running word count and a 32-bit additive checksum of the downloaded image. Words are buffered in a small FIFO so that the receive and transmit frame timing may drift without losing data under normal load.

## Interface
- BAUD_CNT_MAX, default `CLK_FREQ / `UART_BPS: clock cycles per UART bit; must be ≥ 4.
- FIFO_DEPTH, default 4: word FIFO entries; power of two, 2–16.
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- debug_en_i  input  1  download mode enable, same signal that enables the downloader; low = synchronous clear
- mem_wr_en_i  input  1  one-cycle write strobe from the downloader
- mem_wr_data_i  input  32  word being written to memory
- uart_tx_o  output  1  echo serial line, idle high, 8N1, LSB first
- busy_o  output  1  FIFO non-empty or TX state ≠ IDLE
- overflow_o  output  1  sticky; a word was dropped because the FIFO was full
- word_cnt_o  output  16  number of write strobes seen, wraps mod 2^16
- checksum_o  output  32  sum of all strobed words, mod 2^32

## Operation
- Reset (async) and debug_en_i == 0 (sync, every edge): FIFO emptied, TX FSM → IDLE, uart_tx_o = 1, busy_o = 0, overflow_o = 0, word_cnt_o = 0, checksum_o = 0. Clearing aborts any frame mid-bit; the line returns high on the next edge.
- Write strobe (mem_wr_en_i = 1 and debug_en_i = 1):
  - word_cnt_o increments.
  - checksum_o += mem_wr_data_i.
  - Both updates occur even if the word is dropped.
  - The word is pushed if FIFO count < FIFO_DEPTH at that edge. If the FIFO is full, the word is dropped and overflow_o is set. A pop on the same edge does not rescue a push into a full FIFO.
- TX FSM states:
  - IDLE: uart_tx_o = 1. If the FIFO is non-empty, pop the head word into the shift register, set byte_idx = 0, and go to START.
  - START: uart_tx_o = 0 for BAUD_CNT_MAX cycles, then go to DATA with bit_idx = 0.
  - DATA: uart_tx_o = current byte[bit_idx] for BAUD_CNT_MAX cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: uart_tx_o = 1 for BAUD_CNT_MAX cycles. If byte_idx < 3, increment byte_idx and go to START. Otherwise go to IDLE.
- Byte order is little-endian: data[7:0], [15:8], [23:16], [31:24]. This matches the downloader's byte assembly.
- A single baud counter runs 0..BAUD_CNT_MAX-1. It is held at 0 in IDLE and restarts at 0 on every state or bit change.
- uart_tx_o is driven from a register; no combinational path exists from any input to uart_tx_o.
- FIFO: registered read/write pointers and count. A simultaneous push and pop leaves the count unchanged.

## Timing
- For a write strobe sampled at edge k, with the FIFO empty and the FSM in IDLE: the word is in the FIFO after edge k, it is popped at edge k+1, and uart_tx_o falls at edge k+1.
- Each byte frame is 10 × BAUD_CNT_MAX cycles. A word is 40 × BAUD_CNT_MAX cycles.
- Bytes within a word are sent back to back, with no idle cycles.
- Between consecutive words there is exactly one IDLE cycle with uart_tx_o = 1.
- busy_o is registered-state derived. It falls on the edge where the FSM enters IDLE with the FIFO empty, which is edge k+1+40·BAUD_CNT_MAX for a single word.
- word_cnt_o, checksum_o and overflow_o update on edge k (one-cycle latency from the strobe).

## Test plan
- Reset check: assert rst_n = 0 mid-run → immediately uart_tx_o = 1, busy_o = 0, overflow_o = 0, word_cnt_o = 0, checksum_o = 0.
- Single word, BAUD_CNT_MAX = 16: strobe 0x12345678 at edge k.
  - Expect the line low at k+1 and the decoded bytes 0x78, 0x56, 0x34, 0x12, each 160 cycles.
  - Expect busy_o to fall at k+641, word_cnt_o = 1, and checksum_o = 0x12345678.
- Overflow, FIFO_DEPTH = 4: six strobes on consecutive edges with words 1..6.
  - Expect echoed words 1, 2, 3, 4, 5, with word 6 dropped.
  - Expect overflow_o = 1, word_cnt_o = 6, and checksum_o = 21.
- Back-to-back words: two strobes 0x000000FF and 0xA5A5A5A5, 640+ cycles apart. Expect an exact 8-byte echo and exactly one high IDLE cycle between the two words.
- Mid-frame abort: drop debug_en_i during DATA of byte 2.
  - Expect uart_tx_o = 1 on the next edge, the FIFO empty, and all counters at 0.
  - Re-enable and strobe 0x0000005A. Expect a clean echo of 0x5A, 0x00, 0x00, 0x00.
- Checksum wrap: strobe 0xFFFFFFFF then 0x00000002 → checksum_o = 0x00000001 and word_cnt_o = 2. Also preset 65535 strobes, then one more → word_cnt_o = 0.

Source files
------------

// File: rtl/uart_debug_echo_if.sv
// Downloader memory-write stream feeding the echo stage.
// The downloader drives the master side; the echo stage listens as slave.
interface uart_debug_echo_if;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  modport master (
    output mem_wr_en,
    output mem_wr_data
  );

  modport slave (
    input mem_wr_en,
    input mem_wr_data
  );
endinterface

// File: rtl/uart_debug_echo.sv
// Download-echo stage: buffers downloaded words in a FIFO and retransmits
// them as 8N1 UART bytes, while keeping a word count and additive checksum.
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef UART_BPS
`define UART_BPS 115200
`endif

module uart_debug_echo #(
  parameter int BAUD_CNT_MAX = `CLK_FREQ / `UART_BPS,
  parameter int FIFO_DEPTH   = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             debug_en_i,
  uart_debug_echo_if.slave wr,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic [15:0]      word_cnt_o,
  output logic [31:0]      checksum_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_CNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_word_cnt;
  logic [31:0]   r_checksum;

  state_t        r_state;
  logic          r_tx;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic [31:0]   r_shift;

  logic w_strobe;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_baud_end;

  assign w_strobe   = debug_en_i && wr.mem_wr_en;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  // Full is judged on the registered count, so a same-edge pop never
  // makes room for a push.
  assign w_push     = w_strobe && !w_full;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_baud_end = (r_baud == BW'(BAUD_CNT_MAX - 1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr.mem_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_word_cnt <= '0;
      r_checksum <= '0;
    end else if (!debug_en_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_word_cnt <= '0;
      r_checksum <= '0;
    end else begin
      if (w_strobe) begin
        r_word_cnt <= r_word_cnt + 16'd1;
        r_checksum <= r_checksum + wr.mem_wr_data;
        if (w_full) begin
          r_overflow <= 1'b1;
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // The shift register moves right one bit per data bit, so after eight
  // bits the next little-endian byte already sits in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
    end else if (!debug_en_i) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_byte  <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte != 2'd3) begin
              r_byte  <= r_byte + 2'd1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_tx_o  = r_tx;
  assign busy_o     = (r_count != '0) || (r_state != S_IDLE);
  assign overflow_o = r_overflow;
  assign word_cnt_o = r_word_cnt;
  assign checksum_o = r_checksum;

endmodule

// File: tb/tb_uart_debug_echo.sv
// Bench for uart_debug_echo: table-driven single words, a serial decoder
// feeding a byte scoreboard, and hand-written multi-cycle corner cases.
module tb_uart_debug_echo;

  localparam int BAUD = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        debug_en;
  logic        tx;
  logic        busy;
  logic        ovf;
  logic [15:0] wcnt;
  logic [31:0] csum;

  uart_debug_echo_if wr_if();

  uart_debug_echo #(
    .BAUD_CNT_MAX(BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .debug_en_i(debug_en),
    .wr        (wr_if),
    .uart_tx_o (tx),
    .busy_o    (busy),
    .overflow_o(ovf),
    .word_cnt_o(wcnt),
    .checksum_o(csum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  bit rx_check = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serial decoder sampling on the falling edge, mid-bit.
  int         rx_st = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (!rst_n || !debug_en) begin
      rx_st = 0;
      rx_cnt = 0;
    end else if (rx_st == 0) begin
      if (tx === 1'b0) begin
        rx_st = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 8 && rx_check)
        check("rx_start_bit", {31'b0, tx}, 32'd0);
      if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0)
        rx_byte[3'((rx_cnt - 24) / 16)] = tx;
      if (rx_cnt == 152) begin
        rx_st = 0;
        if (rx_check) begin
          check("rx_stop_bit", {31'b0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_unexpected: got byte %h expected none", rx_byte);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", {24'b0, rx_byte}, {24'b0, rx_exp});
          end
        end
      end
    end
  end

  task automatic strobe(input logic [31:0] w, input bit echo);
    wr_if.mem_wr_en   = 1'b1;
    wr_if.mem_wr_data = w;
    if (echo)
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    @(negedge clk);
    wr_if.mem_wr_en = 1'b0;
  endtask

  task automatic clear_dut();
    debug_en = 1'b0;
    @(negedge clk);
    debug_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    check("drain_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_cnt;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h12345678, 16'd1, 32'h12345678};
    vecs[1] = '{32'h00000001, 16'd2, 32'h12345679};
    vecs[2] = '{32'h80000000, 16'd3, 32'h92345679};
    vecs[3] = '{32'hCAFEF00D, 16'd4, 32'h5D334686};

    rst_n = 1'b0;
    debug_en = 1'b1;
    wr_if.mem_wr_en = 1'b0;
    wr_if.mem_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_cnt", {16'b0, wcnt}, 32'd0);
    check("rst_sum", csum, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Isolated words: start at k+1, busy falls at k+641.
    for (int v = 0; v < 4; v++) begin
      strobe(vecs[v].word, 1'b1);
      check("vec_cnt", {16'b0, wcnt}, {16'b0, vecs[v].exp_cnt});
      check("vec_sum", csum, vecs[v].exp_sum);
      check("vec_busy_k", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("vec_start_k1", {31'b0, tx}, 32'd0);
      repeat (639) @(negedge clk);
      check("vec_busy_k640", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("vec_busy_k641", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check("vec_queue", exp_q.size(), 32'd0);
    end

    // Overflow: six consecutive strobes into a depth-4 FIFO.
    clear_dut();
    for (int i = 1; i <= 6; i++) strobe(i, i <= 5);
    check("ovf_flag", {31'b0, ovf}, 32'd1);
    check("ovf_cnt", {16'b0, wcnt}, 32'd6);
    check("ovf_sum", csum, 32'd21);
    wait_idle(4000);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);

    // Back-to-back: second word arrives during the last stop bit.
    clear_dut();
    strobe(32'h000000FF, 1'b1);
    repeat (639) @(negedge clk);
    strobe(32'hA5A5A5A5, 1'b1);
    @(negedge clk);
    check("b2b_idle_high", {31'b0, tx}, 32'd1);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_second_start", {31'b0, tx}, 32'd0);
    wait_idle(1000);

    // Abort during the data bits of byte 2.
    clear_dut();
    strobe(32'h11223344, 1'b0);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    repeat (376) @(negedge clk);
    check("abort_pre_busy", {31'b0, busy}, 32'd1);
    debug_en = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_cnt", {16'b0, wcnt}, 32'd0);
    check("abort_sum", csum, 32'd0);
    check("abort_ovf", {31'b0, ovf}, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);
    debug_en = 1'b1;
    @(negedge clk);
    strobe(32'h0000005A, 1'b1);
    wait_idle(1000);
    check("reecho_cnt", {16'b0, wcnt}, 32'd1);
    check("reecho_sum", csum, 32'h5A);

    // Checksum wrap.
    clear_dut();
    strobe(32'hFFFFFFFF, 1'b1);
    strobe(32'h00000002, 1'b1);
    check("wrap_sum", csum, 32'h1);
    check("wrap_cnt", {16'b0, wcnt}, 32'd2);
    wait_idle(2000);

    // Word counter wrap after 65536 strobes.
    clear_dut();
    rx_check = 1'b0;
    repeat (65535) strobe(32'h0, 1'b0);
    check("cnt_65535", {16'b0, wcnt}, 32'hFFFF);
    strobe(32'h0, 1'b0);
    check("cnt_wrap", {16'b0, wcnt}, 32'd0);
    check("cnt_wrap_ovf", {31'b0, ovf}, 32'd1);

    // Asynchronous reset in the middle of a frame.
    strobe(32'h00001234, 1'b0);
    repeat (50) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_tx", {31'b0, tx}, 32'd1);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ovf", {31'b0, ovf}, 32'd0);
    check("arst_cnt", {16'b0, wcnt}, 32'd0);
    check("arst_sum", csum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
